// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled line with 3-sample majority vote, 5-8 data bits,
// optional parity, one stop bit, and a valid/ready holding register with sticky overrun.
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic       enable,
    input  logic [1:0] wlen,
    input  logic       pen,
    input  logic       eps,
    output logic [7:0] rx_data,
    output logic       rx_fe,
    output logic       rx_pe,
    output logic       rx_be,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_oe,
    input  logic       oe_clr,
    output logic       busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd_s;
    logic [CW-1:0]          cnt;
    logic                   samp_a;
    logic                   samp_b;
    logic [2:0]             bit_idx;
    logic                   armed;
    logic [7:0]             word;
    logic                   par_bit;
    logic [1:0]             wlen_l;
    logic                   pen_l;
    logic                   eps_l;

    logic tick;
    logic start_det;
    logic decide;
    logic wrap;
    logic maj;
    logic last_bit;
    logic frame_done;
    logic fe;
    logic pe;
    logic be;
    logic accept;

    // Preset to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync <= '1;
        else
            sync <= {sync[SYNC_STAGES-2:0], rxd};
    end

    assign rxd_s      = sync[SYNC_STAGES-1];
    assign tick       = baud_tick && enable;
    assign start_det  = (state == IDLE) && armed && tick && !rxd_s;
    assign decide     = tick && (cnt == S2);
    assign wrap       = tick && (cnt == LAST);
    assign maj        = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
    assign last_bit   = (bit_idx == (3'(wlen_l) + 3'd4));
    assign frame_done = (state == STOP) && decide;
    assign fe         = !maj;
    assign pe         = pen_l && ((^word ^ par_bit) != !eps_l);
    assign be         = fe && (word == 8'h00) && !par_bit;
    assign accept     = !rx_valid || rx_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_det) state_next = START;
                START: begin
                    if (decide && maj)
                        state_next = IDLE;
                    else if (wrap)
                        state_next = DATA;
                end
                DATA:    if (wrap && last_bit) state_next = pen_l ? PARITY : STOP;
                PARITY:  if (wrap) state_next = STOP;
                STOP:    if (decide) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame format is captured at the start edge so mid-frame config changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            bit_idx <= '0;
            word    <= '0;
            par_bit <= 1'b0;
            wlen_l  <= '0;
            pen_l   <= 1'b0;
            eps_l   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            if (start_det) begin
                cnt     <= '0;
                bit_idx <= '0;
                word    <= '0;
                par_bit <= 1'b0;
                wlen_l  <= wlen;
                pen_l   <= pen;
                eps_l   <= eps;
            end else if (tick && state != IDLE) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                if (cnt == S0)
                    samp_a <= rxd_s;
                if (cnt == S1)
                    samp_b <= rxd_s;
                if (state == DATA && cnt == S2)
                    word[bit_idx] <= maj;
                if (state == DATA && cnt == LAST)
                    bit_idx <= bit_idx + 1'b1;
                if (state == PARITY && cnt == S2)
                    par_bit <= maj;
            end

            // A low stop bit disarms so a held break yields a single word.
            if (!enable)
                armed <= 1'b0;
            else if (frame_done && fe)
                armed <= 1'b0;
            else if (state == IDLE && rxd_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data  <= '0;
            rx_fe    <= 1'b0;
            rx_pe    <= 1'b0;
            rx_be    <= 1'b0;
            rx_valid <= 1'b0;
            rx_oe    <= 1'b0;
        end else begin
            if (frame_done && accept) begin
                rx_data  <= word;
                rx_fe    <= fe;
                rx_pe    <= pe;
                rx_be    <= be;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (frame_done && !accept)
                rx_oe <= 1'b1;
            else if (oe_clr)
                rx_oe <= 1'b0;
        end
    end

endmodule
